seq_alu: RTL and testbench

- Parametrised, registered successor to the 16-op combinational ALU.
- Keeps the same 4-bit opcode map and the Out_1/Out_0/cFlag/zFlag/vFlag result format.
- Adds WIDTH generality, a valid/ready handshake on both sides, and an iterative multi-cycle multiplier.
- Sits between the datapath register file and the writeback stage.

---
 rtl/alu_pkg.sv | 116 +++++++++++
 rtl/seq_alu_mul.sv | 73 +++++++
 rtl/seq_alu.sv | 122 ++++++++++++
 tb/tb_seq_alu.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode map, sequencer states, single-cycle evaluator.
// Combinational only; no latency.
// No flow control here; callers own the handshake.
package alu_pkg;

    localparam int ALU_MAX_WIDTH = 64;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_ROL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_NAND = 4'd10;
    localparam logic [3:0] OP_XOR  = 4'd11;
    localparam logic [3:0] OP_XNOR = 4'd12;
    localparam logic [3:0] OP_NOT  = 4'd13;
    localparam logic [3:0] OP_EQ   = 4'd14;
    localparam logic [3:0] OP_NEG  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    typedef logic [ALU_MAX_WIDTH:0] alu_wide_t;

    typedef struct packed {
        logic [ALU_MAX_WIDTH-1:0] res;
        logic                     c;
        logic                     v;
    } alu_res_t;

    // Operands arrive zero-extended to ALU_MAX_WIDTH; 'width' is the live word
    // width, so the extra top bit of alu_wide_t catches the carry. MUL yields 0.
    function automatic alu_res_t alu_eval(input logic [3:0]               sel,
                                          input logic [ALU_MAX_WIDTH-1:0] a_in,
                                          input logic [ALU_MAX_WIDTH-1:0] b_in,
                                          input int                       width);
        alu_wide_t one;
        alu_wide_t mask;
        alu_wide_t top;
        alu_wide_t a;
        alu_wide_t b;
        alu_wide_t y;
        logic      a_msb;
        logic      b_msb;
        logic      y_msb;
        alu_res_t  r;

        one   = alu_wide_t'(1);
        mask  = (one << width) - one;
        top   = one << (width - 1);
        a     = alu_wide_t'(a_in) & mask;
        b     = alu_wide_t'(b_in) & mask;
        a_msb = |(a & top);
        b_msb = |(b & top);
        y     = '0;
        r     = '0;

        case (sel)
            OP_ADD: begin
                y     = a + b;
                y_msb = |(y & top);
                r.c   = |(y & ~mask);
                r.v   = (a_msb == b_msb) && (y_msb != a_msb);
            end
            OP_SUB: begin
                y     = a + (~b & mask) + one;
                y_msb = |(y & top);
                r.c   = |(y & ~mask);
                r.v   = (a_msb != b_msb) && (y_msb != a_msb);
            end
            OP_MUL:  y = '0;
            OP_SHL: begin
                y   = a << 1;
                r.c = a_msb;
            end
            OP_SHR: begin
                y   = a >> 1;
                r.c = a[0];
            end
            OP_ROL: begin
                y   = (a << 1) | alu_wide_t'(a_msb);
                r.c = a_msb;
            end
            OP_ROR: begin
                y   = (a >> 1) | (a[0] ? top : '0);
                r.c = a[0];
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_NAND: y = ~(a & b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_EQ:   y = alu_wide_t'(a == b);
            OP_NEG: begin
                y   = (~a & mask) + one;
                r.c = (a == '0);
                r.v = (a == top);
            end
            default: y = '0;
        endcase

        r.res = ALU_MAX_WIDTH'(y & mask);
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative unsigned multiplier, MUL_BITS of B retired per cycle.
// Latency WIDTH/MUL_BITS cycles after start; done flags the final iteration cycle.
// No backpressure: start is only honoured while idle, product valid alongside done.
module seq_alu_mul
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int N     = WIDTH / MUL_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] digit_ext;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic               last;

    always_comb begin
        a_ext     = {{WIDTH{1'b0}}, a_q};
        digit_ext = {{(2*WIDTH-MUL_BITS){1'b0}}, b_q[MUL_BITS-1:0]};
        partial   = (a_ext * digit_ext) << (int'(cnt) * MUL_BITS);
        acc_nxt   = acc + partial;
        last      = (cnt == CNT_W'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            a_q    <= a;
            b_q    <= b;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc <= acc_nxt;
            b_q <= b_q >> MUL_BITS;
            if (last) begin
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // The final sum is exposed combinationally so the caller can register it
    // on the same edge that retires the last iteration.
    assign busy    = busy_q;
    assign done    = busy_q && last;
    assign product = acc_nxt;

endmodule

// File: rtl/seq_alu.sv
// Registered 16-op ALU with valid/ready on both sides and an iterative multiplier.
// Latency: 1 cycle for single-cycle ops, WIDTH/MUL_BITS+1 cycles for MUL.
// One op in flight; result held in DONE until out_ready, in_ready low meanwhile.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out_1,
    output logic [WIDTH-1:0] Out_0,
    output logic             cFlag,
    output logic             zFlag,
    output logic             vFlag
);

    alu_state_t         state;
    alu_state_t         state_nxt;
    alu_res_t           op_res;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               load_op;
    logic               load_mul;

    always_comb begin
        op_res = alu_eval(Sel, ALU_MAX_WIDTH'(A), ALU_MAX_WIDTH'(B), WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_start = 1'b0;
        load_op   = 1'b0;
        load_mul  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (Sel == OP_MUL) begin
                        mul_start = 1'b1;
                        state_nxt = MUL;
                    end else begin
                        load_op   = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_busy && mul_done) begin
                    load_mul  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // op_res bits above WIDTH are masked to zero, so the full-width compare
    // equals the zero test over {Out_1, Out_0} with Out_1 forced to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            Out_1 <= '0;
            Out_0 <= '0;
            cFlag <= 1'b0;
            zFlag <= 1'b0;
            vFlag <= 1'b0;
        end else if (load_op) begin
            Out_1 <= '0;
            Out_0 <= op_res.res[WIDTH-1:0];
            cFlag <= op_res.c;
            zFlag <= (op_res.res == '0);
            vFlag <= op_res.v;
        end else if (load_mul) begin
            Out_1 <= mul_product[2*WIDTH-1:WIDTH];
            Out_0 <= mul_product[WIDTH-1:0];
            cFlag <= 1'b0;
            zFlag <= (mul_product == '0);
            vFlag <= |mul_product[2*WIDTH-1:WIDTH];
        end
    end

    seq_alu_mul #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one MUL_BITS=1 instance, one MUL_BITS=4 instance.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid4;
    logic        in_ready, in_ready4;
    logic [15:0] A, B;
    logic [3:0]  Sel;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [15:0] Out_1, Out_0, Out_1_4, Out_0_4;
    logic        cFlag, zFlag, vFlag, cFlag4, zFlag4, vFlag4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(16), .MUL_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Sel(Sel), .out_valid(out_valid), .out_ready(out_ready),
        .Out_1(Out_1), .Out_0(Out_0), .cFlag(cFlag), .zFlag(zFlag), .vFlag(vFlag)
    );

    seq_alu #(.WIDTH(16), .MUL_BITS(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A), .B(B), .Sel(Sel), .out_valid(out_valid4), .out_ready(out_ready),
        .Out_1(Out_1_4), .Out_0(Out_0_4), .cFlag(cFlag4), .zFlag(zFlag4), .vFlag(vFlag4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one op, scrambles the inputs after the accept edge, and counts
    // edges (accept edge included) until out_valid, bounded at 60.
    task automatic do_op(input bit use4, input logic [3:0] sel, input logic [15:0] a,
                         input logic [15:0] b, output int lat);
        Sel = sel;
        A   = a;
        B   = b;
        if (use4) in_valid4 = 1'b1;
        else      in_valid  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                in_valid  = 1'b0;
                in_valid4 = 1'b0;
                A   = 16'hA5A5;
                B   = 16'h5A5A;
                Sel = 4'd11;
            end
        end while (!(use4 ? out_valid4 : out_valid) && lat < 60);
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, in_ready4, out_valid4} !== 4'b1010)
            $display("FAIL reset_hs: got %b want 1010", {in_ready, out_valid, in_ready4, out_valid4});
        else passed++;
        total++;
        if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== 35'd0)
            $display("FAIL reset_out: got %h %h %b%b%b want 0", Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
    endtask

    task automatic test_add();
        int lat;
        do_op(1'b0, 4'd0, 16'hFFFF, 16'h0001, lat);
        total++;
        if (lat !== 1) $display("FAIL add_lat: got %0d want 1", lat);
        else passed++;
        total++;
        if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== {16'h0000, 16'h0000, 3'b110})
            $display("FAIL add_res: got %h %h %b%b%b want 0000 0000 110", Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
        retire();
    endtask

    task automatic test_sub();
        logic [15:0] va[3]  = '{16'h0003, 16'h0002, 16'h8000};
        logic [15:0] vb[3]  = '{16'h0002, 16'h0003, 16'h0001};
        logic [15:0] vr[3]  = '{16'h0001, 16'hFFFF, 16'h7FFF};
        logic [2:0]  vf[3]  = '{3'b100, 3'b000, 3'b101};
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 4'd1, va[i], vb[i], lat);
            total++;
            if ({lat == 1, Out_1, Out_0, cFlag, zFlag, vFlag} !== {1'b1, 16'h0000, vr[i], vf[i]})
                $display("FAIL sub_%0d: got lat=%0d %h %h %b%b%b want lat=1 0000 %h %b",
                         i, lat, Out_1, Out_0, cFlag, zFlag, vFlag, vr[i], vf[i]);
            else passed++;
            retire();
        end
    endtask

    task automatic test_mul();
        int lat;
        do_op(1'b0, 4'd2, 16'hFFFF, 16'hFFFF, lat);
        total++;
        if (lat !== 17) $display("FAIL mul1_lat: got %0d want 17", lat);
        else passed++;
        total++;
        if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== {16'hFFFE, 16'h0001, 3'b001})
            $display("FAIL mul1_res: got %h %h %b%b%b want fffe 0001 001", Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
        retire();
        do_op(1'b1, 4'd2, 16'hFFFF, 16'hFFFF, lat);
        total++;
        if (lat !== 5) $display("FAIL mul4_lat: got %0d want 5", lat);
        else passed++;
        total++;
        if ({Out_1_4, Out_0_4, cFlag4, zFlag4, vFlag4} !== {16'hFFFE, 16'h0001, 3'b001})
            $display("FAIL mul4_res: got %h %h %b%b%b want fffe 0001 001", Out_1_4, Out_0_4, cFlag4, zFlag4, vFlag4);
        else passed++;
        retire();
        do_op(1'b0, 4'd2, 16'h0003, 16'h0005, lat);
        total++;
        if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== {16'h0000, 16'h000F, 3'b000})
            $display("FAIL mul_small: got %h %h %b%b%b want 0000 000f 000", Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
        retire();
    endtask

    task automatic test_shift();
        logic [15:0] exp_sh[4] = '{16'h0002, 16'h4000, 16'h0003, 16'hC000};
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(1'b0, 4'(i + 3), 16'h8001, 16'h0000, lat);
            total++;
            if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== {16'h0000, exp_sh[i], 3'b100})
                $display("FAIL shift_sel%0d: got %h %h %b%b%b want 0000 %h 100",
                         i + 3, Out_1, Out_0, cFlag, zFlag, vFlag, exp_sh[i]);
            else passed++;
            retire();
        end
    endtask

    task automatic test_logic();
        logic [3:0]  ls[5] = '{4'd7, 4'd11, 4'd14, 4'd15, 4'd15};
        logic [15:0] la[5] = '{16'hF0F0, 16'hFF00, 16'h1234, 16'h8000, 16'h0000};
        logic [15:0] lb[5] = '{16'h3C3C, 16'h0FF0, 16'h1234, 16'h0000, 16'h0000};
        logic [15:0] lr[5] = '{16'h3030, 16'hF0F0, 16'h0001, 16'h8000, 16'h0000};
        logic [2:0]  lf[5] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b110};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, ls[i], la[i], lb[i], lat);
            total++;
            if ({Out_1, Out_0, cFlag, zFlag, vFlag} !== {16'h0000, lr[i], lf[i]})
                $display("FAIL logic_%0d: got %h %h %b%b%b want 0000 %h %b",
                         i, Out_1, Out_0, cFlag, zFlag, vFlag, lr[i], lf[i]);
            else passed++;
            retire();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(1'b0, 4'd0, 16'h0005, 16'h0006, lat);
        Sel = 4'd0;
        A   = 16'h0001;
        B   = 16'h0001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({out_valid, in_ready, Out_1, Out_0, cFlag, zFlag, vFlag} !== {2'b10, 16'h0000, 16'h000B, 3'b000})
                $display("FAIL hold_%0d: got v=%b r=%b %h %h %b%b%b want v=1 r=0 0000 000b 000",
                         i, out_valid, in_ready, Out_1, Out_0, cFlag, zFlag, vFlag);
            else passed++;
            tick();
        end
        in_valid = 1'b0;
        retire();
        total++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL after_retire: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_mul();
        int  lat;
        bit  stray;
        Sel = 4'd2;
        A   = 16'hFFFF;
        B   = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({in_ready, out_valid, Out_1, Out_0, cFlag, zFlag, vFlag} !== {2'b10, 35'd0})
            $display("FAIL mid_mul_reset: got r=%b v=%b %h %h %b%b%b want r=1 v=0 0",
                     in_ready, out_valid, Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
        do_op(1'b0, 4'd0, 16'h0001, 16'h0002, lat);
        total++;
        if ({lat == 1, Out_1, Out_0, cFlag, zFlag, vFlag} !== {1'b1, 16'h0000, 16'h0003, 3'b000})
            $display("FAIL add_after_reset: got lat=%0d %h %h %b%b%b want lat=1 0000 0003 000",
                     lat, Out_1, Out_0, cFlag, zFlag, vFlag);
        else passed++;
        retire();
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) stray = 1'b1;
            tick();
        end
        total++;
        if (stray !== 1'b0) $display("FAIL stray_valid: got %b want 0", stray);
        else passed++;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        out_ready = 1'b0;
        A   = '0;
        B   = '0;
        Sel = '0;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_logic();
        test_backpressure();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
